// File: rtl/ram_scan_pkg.sv
// Shared types and default sizes for the RAM scan reader
// and the RAM tester top that reuses it.
package ram_scan_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 2;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        PRESENT,
        DONE
    } scan_state_e;

endpackage

// File: rtl/scan_timer.sv
// Idle-period counter: counts enabled cycles, flags the
// last cycle of the period, cleared between sweeps.
module scan_timer #(
    parameter int PERIOD = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expire
);

    localparam int CW = $clog2(PERIOD);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Clear has priority; otherwise count while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == CW'(PERIOD - 1));

endmodule

// File: rtl/ram_scan_reader.sv
// Sweeps every RAM address, presents each word on a
// valid/ready port and keeps a packed snapshot image.
module ram_scan_reader
    import ram_scan_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SCAN_PERIOD = 1000,
    parameter int AUTO        = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    output logic                             r_en,
    output logic [ADDR_W-1:0]                r_addr,
    input  logic [DATA_W-1:0]                r_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [ADDR_W-1:0]                out_addr,
    output logic [DATA_W-1:0]                out_data,
    output logic [DATA_W*(1<<ADDR_W)-1:0]    snapshot,
    output logic                             busy,
    output logic                             done
);

    localparam int SNAP_W = DATA_W * (1 << ADDR_W);

    scan_state_e state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] oaddr_q;
    logic [DATA_W-1:0] odata_q;
    logic [SNAP_W-1:0] snap_q;

    logic expire;
    logic trigger;
    logic last;

    // A start coinciding with expiry is still one trigger.
    assign trigger = (state_q == IDLE) &&
                     (start || ((AUTO != 0) && expire));
    assign last = (addr_q == {ADDR_W{1'b1}});

    scan_timer #(
        .PERIOD (SCAN_PERIOD)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .en     ((AUTO != 0) && (state_q == IDLE)),
        .clr    (trigger || (state_q == DONE)),
        .expire (expire)
    );

    // Next-state and scan-address logic.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        unique case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d = READ;
                    addr_d  = '0;
                end
            end
            READ:    state_d = WAIT;
            WAIT:    state_d = PRESENT;
            PRESENT: begin
                if (out_ready) begin
                    if (last) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = READ;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and scan-address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // Capture the RAM word the cycle after the read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oaddr_q <= '0;
            odata_q <= '0;
            snap_q  <= '0;
        end else if (state_q == WAIT) begin
            oaddr_q <= addr_q;
            odata_q <= r_data;
            snap_q[int'(addr_q)*DATA_W +: DATA_W] <= r_data;
        end
    end

    assign r_en      = (state_q == READ);
    assign r_addr    = r_en ? addr_q : '0;
    assign out_valid = (state_q == PRESENT);
    assign out_addr  = oaddr_q;
    assign out_data  = odata_q;
    assign snapshot  = snap_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_ram_scan_reader.sv
// Directed bench: a manual-start reader (AUTO=0) and an
// auto-sweeping reader (SCAN_PERIOD=20) over one RAM image.
module tb_ram_scan_reader;

    localparam int AW = 4;
    localparam int DW = 2;
    localparam int NW = 16;

    logic clk = 1'b0;
    logic rst;
    logic start0, ready0, start1, ready1;
    logic r_en0, r_en1;
    logic [AW-1:0] r_addr0, r_addr1;
    logic [DW-1:0] r_data0 = '0;
    logic [DW-1:0] r_data1 = '0;
    logic out_valid0, out_valid1;
    logic [AW-1:0] out_addr0, out_addr1;
    logic [DW-1:0] out_data0, out_data1;
    logic [DW*NW-1:0] snap0, snap1;
    logic busy0, busy1, done0, done1;

    logic [DW-1:0] mem [NW];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Synchronous-read RAM model, one read port per reader.
    always @(posedge clk) begin
        if (r_en0) r_data0 <= mem[r_addr0];
        if (r_en1) r_data1 <= mem[r_addr1];
    end

    ram_scan_reader #(
        .ADDR_W(AW), .DATA_W(DW), .SCAN_PERIOD(1000), .AUTO(0)
    ) dut0 (
        .clk(clk), .rst(rst), .start(start0),
        .r_en(r_en0), .r_addr(r_addr0), .r_data(r_data0),
        .out_valid(out_valid0), .out_ready(ready0),
        .out_addr(out_addr0), .out_data(out_data0),
        .snapshot(snap0), .busy(busy0), .done(done0)
    );

    ram_scan_reader #(
        .ADDR_W(AW), .DATA_W(DW), .SCAN_PERIOD(20), .AUTO(1)
    ) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .r_en(r_en1), .r_addr(r_addr1), .r_data(r_data1),
        .out_valid(out_valid1), .out_ready(ready1),
        .out_addr(out_addr1), .out_data(out_data1),
        .snapshot(snap1), .busy(busy1), .done(done1)
    );

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    // One manual sweep on dut0; checks every transfer
    // against the RAM image, optional stall and mid-sweep start.
    task automatic sweep(input int stall_addr,
                         input int stall_len,
                         input bit pulse_mid,
                         output int ntr,
                         output int ndone,
                         output int done_at);
        int stalled;
        int cyc;
        stalled = 0;
        ntr = 0;
        ndone = 0;
        done_at = -1;
        ready0 = 1'b1;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        cyc = 1;
        while (cyc <= 49 + stall_len + 15) begin
            if (pulse_mid) start0 = (cyc == 10);
            if (done0) begin
                ndone++;
                done_at = cyc;
            end
            if (out_valid0) begin
                chk("xfer_addr", out_addr0, 64'(ntr % NW));
                chk("xfer_data", out_data0, mem[ntr % NW]);
                if (ntr == stall_addr && stalled == 0) begin
                    ready0 = 1'b0;
                    for (int k = 0; k < stall_len; k++) begin
                        @(posedge clk); #1;
                        cyc++;
                        stalled++;
                        chk("stall_valid", out_valid0, 1);
                        chk("stall_addr", out_addr0, stall_addr);
                        chk("stall_data", out_data0, mem[stall_addr]);
                        chk("stall_ren", r_en0, 0);
                    end
                    ready0 = 1'b1;
                end
                ntr++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start0 = 1'b0;
    endtask

    initial begin
        int n;
        int ntr, ndone, done_at;
        bit found;

        for (int a = 0; a < NW; a++) mem[a] = DW'(a % 4);
        rst = 1'b1;
        start0 = 1'b0;
        ready0 = 1'b1;
        start1 = 1'b0;
        ready1 = 1'b1;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_r_en", r_en0, 0);
        chk("rst_r_addr", r_addr0, 0);
        chk("rst_out_valid", out_valid0, 0);
        chk("rst_out_addr", out_addr0, 0);
        chk("rst_out_data", out_data0, 0);
        chk("rst_snapshot", snap0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_busy_auto", busy1, 0);
        rst = 1'b0;

        // First auto sweep 20 cycles after reset release.
        n = 0;
        while (n < 100) begin
            @(posedge clk); #1;
            n++;
            if (r_en1) break;
        end
        chk("auto_first_start", n, 20);

        // Auto sweep: READ to DONE is 3*16 cycles.
        n = 0;
        while (!done1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("auto_sweep_len", n, 48);
        chk("auto_snapshot", snap1, 32'hE4E4E4E4);

        // Next auto sweep 20 idle cycles after the sweep ends.
        @(posedge clk); #1;
        n = 0;
        while (!r_en1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("auto_period", n, 20);
        chk("manual_no_auto", busy0, 0);

        // Full manual sweep, ready held high.
        sweep(-1, 0, 1'b0, ntr, ndone, done_at);
        chk("sweep_ntr", ntr, 16);
        chk("sweep_ndone", ndone, 1);
        chk("sweep_done_at", done_at, 49);
        chk("sweep_snapshot", snap0, 32'hE4E4E4E4);

        // Backpressure for 5 cycles at address 5.
        sweep(5, 5, 1'b0, ntr, ndone, done_at);
        chk("stall_ntr", ntr, 16);
        chk("stall_done_at", done_at, 54);

        // RAM updated between sweeps; start ignored mid-sweep.
        mem[12] = 2'b11;
        sweep(-1, 0, 1'b1, ntr, ndone, done_at);
        chk("mid_start_ntr", ntr, 16);
        chk("mid_start_ndone", ndone, 1);
        chk("mid_start_idle", busy0, 0);
        chk("upd_snap_word12", snap0[25:24], 2'b11);
        chk("upd_snapshot", snap0, 32'hE7E4E4E4);

        // Reset mid-sweep at address 7.
        ready0 = 1'b1;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        found = 1'b0;
        n = 0;
        while (!found && n < 100) begin
            if (out_valid0 && out_addr0 == 4'd7) begin
                found = 1'b1;
            end else begin
                @(posedge clk); #1;
                n++;
            end
        end
        chk("reach_addr7", found, 1);
        rst = 1'b1;
        #1;
        chk("arst_r_en", r_en0, 0);
        chk("arst_r_addr", r_addr0, 0);
        chk("arst_out_valid", out_valid0, 0);
        chk("arst_out_addr", out_addr0, 0);
        chk("arst_out_data", out_data0, 0);
        chk("arst_snapshot", snap0, 0);
        chk("arst_busy", busy0, 0);
        chk("arst_done", done0, 0);
        @(posedge clk); #1;
        chk("arst_no_done", done0, 0);
        rst = 1'b0;

        sweep(-1, 0, 1'b0, ntr, ndone, done_at);
        chk("post_rst_ntr", ntr, 16);
        chk("post_rst_done_at", done_at, 49);
        chk("post_rst_snapshot", snap0, 32'hE7E4E4E4);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
